vga_timing_gen: RTL

- Downstream consumer of the clock generator's 25 MHz pixel tick.
- Runs entirely on clk_100MHz and advances one pixel on each cycle where pix_tick=1.
- Produces 640x480@60 VGA sync, the active-video flag, pixel coordinates, and line/frame strobes. Renderer and game logic use these.
- frame_tick gives game objects a per-frame update strobe aligned to vertical blanking.

---
 rtl/vga_timing_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing generator on clk_100MHz with pix_tick enable (optional VGA_TEST_PATTERN_EN colour bars)
module vga_timing_gen #(
   parameter int   H_DISPLAY   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_DISPLAY   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic        pix_tick,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        line_tick,
   output logic        frame_tick,
   output logic [11:0] rgb
);

   // Phase boundaries expressed as the counter value that opens each phase
   localparam logic [9:0] H_FRONT_START = 10'(H_DISPLAY);
   localparam logic [9:0] H_SYNC_START  = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_BACK_START  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST        = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_FRONT_START = 10'(V_DISPLAY);
   localparam logic [9:0] V_SYNC_START  = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_BACK_START  = 10'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST        = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

   typedef enum logic [1:0] {
      PH_ACTIVE,
      PH_FRONT,
      PH_SYNC,
      PH_BACK
   } phase_t;

   phase_t     h_phase, v_phase;
   phase_t     h_phase_nx, v_phase_nx;
   logic [9:0] h_nx, v_nx;
   logic       h_wrap;
   logic       video_on_nx;

   // Next-state counters and phase transitions; x and y double as the h/v counters
   always_comb begin
      h_wrap = (x == H_LAST);
      h_nx   = h_wrap ? 10'd0 : x + 10'd1;
      v_nx   = y;
      if (h_wrap) begin
         v_nx = (y == V_LAST) ? 10'd0 : y + 10'd1;
      end

      h_phase_nx = h_phase;
      case (h_phase)
         PH_ACTIVE: if (h_nx == H_FRONT_START) h_phase_nx = PH_FRONT;
         PH_FRONT:  if (h_nx == H_SYNC_START)  h_phase_nx = PH_SYNC;
         PH_SYNC:   if (h_nx == H_BACK_START)  h_phase_nx = PH_BACK;
         PH_BACK:   if (h_wrap)                h_phase_nx = PH_ACTIVE;
         default:                              h_phase_nx = PH_ACTIVE;
      endcase

      v_phase_nx = v_phase;
      if (h_wrap) begin
         case (v_phase)
            PH_ACTIVE: if (v_nx == V_FRONT_START) v_phase_nx = PH_FRONT;
            PH_FRONT:  if (v_nx == V_SYNC_START)  v_phase_nx = PH_SYNC;
            PH_SYNC:   if (v_nx == V_BACK_START)  v_phase_nx = PH_BACK;
            PH_BACK:   if (v_nx == 10'd0)         v_phase_nx = PH_ACTIVE;
            default:                              v_phase_nx = PH_ACTIVE;
         endcase
      end

      video_on_nx = (h_phase_nx == PH_ACTIVE) && (v_phase_nx == PH_ACTIVE);
   end

   // Counters, phases and every output register advance together on pix_tick
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         x          <= '0;
         y          <= '0;
         h_phase    <= PH_ACTIVE;
         v_phase    <= PH_ACTIVE;
         hsync      <= ~SYNC_ACTIVE;
         vsync      <= ~SYNC_ACTIVE;
         video_on   <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else if (pix_tick) begin
         x          <= h_nx;
         y          <= v_nx;
         h_phase    <= h_phase_nx;
         v_phase    <= v_phase_nx;
         hsync      <= (h_phase_nx == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync      <= (v_phase_nx == PH_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on   <= video_on_nx;
         line_tick  <= h_wrap;
         frame_tick <= h_wrap && (v_nx == V_FRONT_START);
      end else begin
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [11:0] bar_rgb;

   // Eight 80-pixel colour bars chosen from the next column
   always_comb begin
      if      (h_nx < 10'd80)  bar_rgb = 12'hFFF;
      else if (h_nx < 10'd160) bar_rgb = 12'hFF0;
      else if (h_nx < 10'd240) bar_rgb = 12'h0FF;
      else if (h_nx < 10'd320) bar_rgb = 12'h0F0;
      else if (h_nx < 10'd400) bar_rgb = 12'hF0F;
      else if (h_nx < 10'd480) bar_rgb = 12'hF00;
      else if (h_nx < 10'd560) bar_rgb = 12'h00F;
      else                     bar_rgb = 12'h000;
   end

   // Colour register tracks x and is blanked outside the active area
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         rgb <= '0;
      end else if (pix_tick) begin
         rgb <= video_on_nx ? bar_rgb : 12'h000;
      end
   end
`else
   assign rgb = 12'h000;
`endif

endmodule
